// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and constants for the load/store unit
package lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } lsu_state_t;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } lsu_size_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [3:0] BE_B = 4'b0001;
   localparam logic [3:0] BE_H = 4'b0011;
   localparam logic [3:0] BE_W = 4'b1111;

   // Anything that is not a byte or half code behaves as a word access.
   function automatic lsu_size_t size_of(input logic [2:0] f3);
      case (f3)
         F3_B, F3_BU: size_of = SZ_B;
         F3_H, F3_HU: size_of = SZ_H;
         default:     size_of = SZ_W;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
      case (size_of(f3))
         SZ_H:    is_misaligned = a[0];
         SZ_W:    is_misaligned = |a;
         default: is_misaligned = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_mem_if.sv
// rtl/lsu_mem_if.sv - req/ack memory port between the load/store unit and memory
interface lsu_mem_if #(
   parameter int N = 32
);
   logic         req;
   logic         we;
   logic [N-1:0] addr;
   logic [N-1:0] wdata;
   logic [3:0]   be;
   logic [N-1:0] rdata;
   logic         ack;

   modport master (output req, we, addr, wdata, be, input rdata, ack);
   modport slave  (input req, we, addr, wdata, be, output rdata, ack);
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte enables, store lane replication and load extraction
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  i_a,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_rdata
);

   lsu_size_t   w_size;
   logic [31:0] w_shift;

   assign w_size  = size_of(i_funct3);
   assign w_shift = i_rdata >> {i_a, 3'b000};

   // funct3[2] distinguishes the unsigned load variants.
   always_comb begin
      o_be    = BE_W;
      o_wdata = i_wdata;
      o_rdata = w_shift;
      case (w_size)
         SZ_B: begin
            o_be    = BE_B << i_a;
            o_wdata = {4{i_wdata[7:0]}};
            o_rdata = {{24{w_shift[7] & ~i_funct3[2]}}, w_shift[7:0]};
         end
         SZ_H: begin
            o_be    = BE_H << i_a;
            o_wdata = {2{i_wdata[15:0]}};
            o_rdata = {{16{w_shift[15] & ~i_funct3[2]}}, w_shift[15:0]};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store unit: IDLE/REQ/DONE FSM, ack timeout, request latches
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int N           = 32,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [N-1:0] addr_i,
   input  logic [N-1:0] wdata_i,
   input  logic         memrd_i,
   input  logic         memwr_i,
   input  logic [2:0]   funct3_i,
   output logic [N-1:0] rdata_o,
   output logic         stall_o,
   output logic         misalign_o,
   output logic         err_o,
   lsu_mem_if.master    mem
);

   lsu_state_t   r_state, w_next;
   logic [7:0]   r_cnt;
   logic [1:0]   r_a;
   logic [2:0]   r_funct3;
   logic         r_req, r_we, r_err;
   logic [N-1:0] r_addr, r_wdata, r_rdata;
   logic [3:0]   r_be;

   logic         w_access, w_misalign, w_start, w_expire;
   logic [1:0]   w_a;
   logic [2:0]   w_f3;
   logic [3:0]   w_be;
   logic [N-1:0] w_wdata, w_rdata;

   assign w_access   = memrd_i | memwr_i;
   assign w_misalign = w_access & is_misaligned(funct3_i, addr_i[1:0]);
   assign w_start    = (r_state == ST_IDLE) & w_access & ~w_misalign;
   assign w_expire   = (r_state == ST_REQ) & ~mem.ack & (r_cnt == 8'(TIMEOUT_CYC - 1));

   // The aligner sees live inputs while issuing and the latched request while waiting for ack.
   assign w_a  = (r_state == ST_IDLE) ? addr_i[1:0] : r_a;
   assign w_f3 = (r_state == ST_IDLE) ? funct3_i    : r_funct3;

   lsu_align u_align (
      .i_a      (w_a),
      .i_funct3 (w_f3),
      .i_wdata  (wdata_i),
      .i_rdata  (mem.rdata),
      .o_be     (w_be),
      .o_wdata  (w_wdata),
      .o_rdata  (w_rdata)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (w_start) w_next = ST_REQ;
         ST_REQ:  if (mem.ack || w_expire) w_next = ST_DONE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      stall_o    = 1'b0;
      misalign_o = 1'b0;
      if (!rst_i) begin
         case (r_state)
            ST_IDLE: begin
               stall_o    = w_start;
               misalign_o = w_misalign;
            end
            ST_REQ:  stall_o = 1'b1;
            default: ;
         endcase
      end
   end

   // rdata_o is only non-zero in the DONE cycle that follows a load ack.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cnt    <= 8'd0;
         r_a      <= 2'd0;
         r_funct3 <= 3'd0;
         r_req    <= 1'b0;
         r_we     <= 1'b0;
         r_err    <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_rdata  <= '0;
         r_be     <= 4'd0;
      end else begin
         r_err   <= w_expire;
         r_rdata <= '0;
         if (w_start) begin
            r_req    <= 1'b1;
            r_we     <= ~memrd_i;
            r_addr   <= {addr_i[N-1:2], 2'b00};
            r_wdata  <= w_wdata;
            r_be     <= w_be;
            r_a      <= addr_i[1:0];
            r_funct3 <= funct3_i;
            r_cnt    <= 8'd0;
         end else if (r_state == ST_REQ) begin
            if (mem.ack) begin
               r_req <= 1'b0;
               if (!r_we) r_rdata <= w_rdata;
            end else if (w_expire) begin
               r_req <= 1'b0;
            end else begin
               r_cnt <= r_cnt + 8'd1;
            end
         end
      end
   end

   assign mem.req   = r_req;
   assign mem.we    = r_we;
   assign mem.addr  = r_addr;
   assign mem.wdata = r_wdata;
   assign mem.be    = r_be;
   assign rdata_o   = r_rdata;
   assign err_o     = r_err;

endmodule
